// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: register-index width,
// the hard-wired zero register and the SRAM wait-state FSM encoding.
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between the ID stage and the EXE/MEM destinations.
// With forwarding present only a load in EXE can force a stall.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int unsigned FWD_EN = 1
) (
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hazard
);

    logic load_use;
    logic src1_hit;
    logic src2_hit;
    logic raw_any;

    assign load_use = exe_wb_en && exe_mem_r_en && (exe_dest != ZERO_REG) &&
                      ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));

    // Writes to r0 are discarded, so a zero source never depends on anything.
    assign src1_hit = (src1 != ZERO_REG) &&
                      (((src1 == exe_dest) && exe_wb_en) || ((src1 == mem_dest) && mem_wb_en));
    assign src2_hit = (src2 != ZERO_REG) &&
                      (((src2 == exe_dest) && exe_wb_en) || ((src2 == mem_dest) && mem_wb_en));

    assign raw_any = src1_hit || (two_src && src2_hit);

    assign hazard = (FWD_EN != 0) ? load_use : raw_any;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: hazard stalls, branch flushes
// and the wait-state FSM for the multi-cycle data SRAM.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idex_freeze,
    output logic             idex_flush,
    output logic             exmem_freeze,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    localparam logic [WaitW:0] WaitLimit = (WaitW + 1)'(MAX_WAIT);

    mem_state_e       state_q;
    logic [WaitW-1:0] wait_cnt_q;
    logic [WaitW:0]   wait_next;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic hazard;
    logic mem_freeze;
    logic count_flush;
    logic count_stall;

    hazard_detect #(
        .FWD_EN(FWD_EN)
    ) u_hazard_detect (
        .src1        (src1),
        .src2        (src2),
        .two_src     (two_src),
        .exe_dest    (exe_dest),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .hazard      (hazard)
    );

    assign mem_freeze  = mem_req && !mem_ready;
    assign count_flush = !mem_freeze && br_taken;
    assign count_stall = !mem_freeze && !br_taken && hazard;
    assign wait_next   = {1'b0, wait_cnt_q} + 1'b1;

    // A held SRAM access masks branch and hazard: ID/EX is frozen, so both
    // re-evaluate once the access completes.
    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idex_freeze  = 1'b0;
        idex_flush   = 1'b0;
        exmem_freeze = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mem_freeze) begin
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            idex_freeze  = 1'b1;
            exmem_freeze = 1'b1;
            memwb_bubble = 1'b1;
        end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hazard) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_freeze) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (mem_ready) begin
                        state_q    <= StIdle;
                        wait_cnt_q <= '0;
                    end else begin
                        if (wait_cnt_q != WaitMax) begin
                            wait_cnt_q <= wait_next[WaitW-1:0];
                        end
                        // Timeout is only a flag; the access keeps waiting for mem_ready.
                        if (wait_next >= WaitLimit) begin
                            mem_timeout_q <= 1'b1;
                        end
                    end
                end
            endcase
            if (count_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (count_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush/freeze sequencer for the 5-stage MIPS pipeline. It detects RAW hazards between the ID stage and the EXE/MEM destinations, and handles taken-branch flushes. It also runs a wait-state FSM for the multi-cycle data SRAM. It drives the freeze and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
FWD_EN, 1, 1 = forwarding unit present (only load-use stalls); 0 = any RAW against EXE/MEM stalls
MAX_WAIT, 15, SRAM wait cycles before the mem_timeout error is raised
CNT_W, 16, width of the saturating stall/flush performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous, active-low reset
src1  in  5  ID-stage source register 1
src2  in  5  ID-stage source register 2
two_src  in  1  ID instruction reads src2 (R-type, store, branch-compare)
exe_dest  in  5  ID/EX Dest
exe_wb_en  in  1  ID/EX WB_EN
exe_mem_r_en  in  1  ID/EX MEM_R_EN
mem_dest  in  5  EX/MEM Dest
mem_wb_en  in  1  EX/MEM WB_EN
br_taken  in  1  EXE-stage branch resolved taken
mem_req  in  1  EX/MEM MEM_R_EN or MEM_W_EN
mem_ready  in  1  SRAM access complete this cycle
pc_freeze  out  1  hold PC
ifid_freeze  out  1  hold IF/ID
ifid_flush  out  1  zero IF/ID
idex_freeze  out  1  hold ID/EX
idex_flush  out  1  load bubble into ID/EX (existing flush input)
exmem_freeze  out  1  hold EX/MEM
memwb_bubble  out  1  load bubble into MEM/WB
mem_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  hazard-stall cycles, saturating
flush_cnt  out  CNT_W  branch-flush events, saturating

Behaviour:
- Freeze/flush outputs are combinational from inputs and state and act in the same cycle. The FSM, wait counter, mem_timeout and the perf counters are registered.
- rst=0 at a clock edge: FSM <= IDLE, wait_cnt <= 0, mem_timeout <= 0, counters <= 0. While rst=0, all freeze outputs are 0 and ifid_flush=idex_flush=memwb_bubble=1.
- hit(s) = (s != 0) && (s == exe_dest && exe_wb_en || s == mem_dest && mem_wb_en). The src2 check applies only when two_src=1.
- FWD_EN=1: hazard = exe_wb_en && exe_mem_r_en && exe_dest != 0 && (src1==exe_dest || two_src && src2==exe_dest).
- FWD_EN=0: hazard = hit(src1) || (two_src && hit(src2)).
- FSM states: IDLE and WAIT.
  - IDLE -> WAIT when mem_req && !mem_ready.
  - WAIT -> IDLE when mem_ready.
  - WAIT holds otherwise.
- mem_freeze = mem_req && !mem_ready in either state.
- wait_cnt increments in WAIT and clears on leaving WAIT. When wait_cnt reaches MAX_WAIT, mem_timeout <= 1. It stays set until reset; the FSM still waits for mem_ready.
- Priority: mem_freeze > br_taken > hazard.
- mem_freeze: pc/ifid/idex/exmem freeze=1, memwb_bubble=1, all flushes 0. br_taken and hazard are ignored because ID/EX is held and they re-evaluate after release.
- br_taken (no mem_freeze): ifid_flush=1, idex_flush=1, no freezes. flush_cnt +1.
- hazard (no freeze, no branch): pc_freeze=1, ifid_freeze=1, idex_flush=1. stall_cnt +1.
- Otherwise all control outputs are 0.
- Counters saturate at 2^CNT_W-1.
- mem_ready while IDLE with mem_req asserted is a zero-wait access: no freeze, no state change.

Decomposition:
- Shared package pipe_pkg holds: REG_W=5, the zero-register constant, and the FSM state encoding (IDLE=1'b0, WAIT=1'b1).
- One sub-module, hazard_detect: purely combinational, parameterised by FWD_EN, producing hazard.

Test Plan:
- FWD_EN=1, exe_dest=5, exe_wb_en=1, exe_mem_r_en=1, src1=5 -> pc_freeze=ifid_freeze=idex_flush=1 for that cycle; stall_cnt 0->1. Same with exe_mem_r_en=0 -> no stall.
- FWD_EN=0, mem_dest=7, mem_wb_en=1, src2=7, two_src=0 -> no stall. With two_src=1 -> stall. With dest=0 -> no stall.
- br_taken=1 together with a hazard -> ifid_flush=idex_flush=1, pc_freeze=0; flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready low for 3 cycles then high -> 3 cycles of all freezes plus memwb_bubble; freezes drop in the mem_ready cycle; FSM back in IDLE on the next edge; br_taken held high throughout causes no flush until release.
- MAX_WAIT=4, mem_ready held low for 6 cycles -> mem_timeout rises after the 4th WAIT cycle and stays 1 after mem_ready. rst=0 for one edge clears it and returns the FSM to IDLE.
- Counter saturation with CNT_W=2 and 5 consecutive hazard cycles -> stall_cnt=3.
